// File: rtl/ex_stage_pkg.sv
// Shared widths, stall encoding, SPECIAL function codes and the decode-to-execute
// bus layout for the execute stage.
package ex_stage_pkg;

    localparam int ID_TO_EX_WD  = 159;
    localparam int EX_TO_MEM_WD = 76;
    localparam int EX_TO_ID_WD  = 38;
    localparam int STALL_WD     = 6;
    localparam int DIV_ITERS    = 32;

    localparam logic STOP    = 1'b1;
    localparam logic NO_STOP = 1'b0;

    localparam logic [5:0] OP_SPECIAL = 6'b000000;
    localparam logic [5:0] FUNC_MFHI  = 6'b010000;
    localparam logic [5:0] FUNC_MTHI  = 6'b010001;
    localparam logic [5:0] FUNC_MFLO  = 6'b010010;
    localparam logic [5:0] FUNC_MTLO  = 6'b010011;
    localparam logic [5:0] FUNC_DIV   = 6'b011010;
    localparam logic [5:0] FUNC_DIVU  = 6'b011011;

    // alu_op bit positions, add in the MSB
    localparam int ALU_ADD  = 11;
    localparam int ALU_SUB  = 10;
    localparam int ALU_SLT  = 9;
    localparam int ALU_SLTU = 8;
    localparam int ALU_AND  = 7;
    localparam int ALU_NOR  = 6;
    localparam int ALU_OR   = 5;
    localparam int ALU_XOR  = 4;
    localparam int ALU_SLL  = 3;
    localparam int ALU_SRL  = 2;
    localparam int ALU_SRA  = 1;
    localparam int ALU_LUI  = 0;

    localparam int SRC1_RS    = 0;
    localparam int SRC1_PC    = 1;
    localparam int SRC1_SA    = 2;
    localparam int SRC2_RT    = 0;
    localparam int SRC2_SIMM  = 1;
    localparam int SRC2_EIGHT = 2;
    localparam int SRC2_ZIMM  = 3;

    typedef enum logic [1:0] {
        DIV_IDLE,
        DIV_BUSY,
        DIV_DONE
    } div_state_e;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] inst;
        logic [11:0] alu_op;
        logic [2:0]  sel_alu_src1;
        logic [3:0]  sel_alu_src2;
        logic        data_ram_en;
        logic [3:0]  data_ram_wen;
        logic        rf_we;
        logic [4:0]  rf_waddr;
        logic        sel_rf_res;
        logic [31:0] rdata1;
        logic [31:0] rdata2;
    } id_to_ex_t;

endpackage

// File: rtl/ex_div.sv
// Iterative restoring divider: one quotient bit per cycle on magnitudes, with the
// sign applied to the outputs once the iterations finish.
module ex_div
    import ex_stage_pkg::*;
#(
    parameter int ITERS = DIV_ITERS
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic        signed_op,
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic        advance,
    output logic        busy,
    output logic        done,
    output logic [31:0] q,
    output logic [31:0] r
);

    localparam int CNT_W = $clog2(ITERS);

    div_state_e       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [31:0]      quo_q, quo_d, rem_q, rem_d, dvs_q, dvs_d;
    logic             qneg_q, qneg_d, rneg_q, rneg_d;
    logic [32:0]      rem_sh, rem_sub;
    logic             sub_ok;
    logic             unused_sub_msb;

    function automatic logic [31:0] abs_if(input logic [31:0] v, input logic en);
        return (en && v[31]) ? (~v + 32'd1) : v;
    endfunction

    function automatic logic [31:0] neg_if(input logic [31:0] v, input logic en);
        return en ? (~v + 32'd1) : v;
    endfunction

    always_comb begin
        rem_sh  = {rem_q, quo_q[31]};
        sub_ok  = rem_sh >= {1'b0, dvs_q};
        rem_sub = rem_sh - {1'b0, dvs_q};
        state_d = state_q;
        cnt_d   = cnt_q;
        quo_d   = quo_q;
        rem_d   = rem_q;
        dvs_d   = dvs_q;
        qneg_d  = qneg_q;
        rneg_d  = rneg_q;
        case (state_q)
            DIV_IDLE: begin
                if (start) begin
                    quo_d   = abs_if(a, signed_op);
                    dvs_d   = abs_if(b, signed_op);
                    rem_d   = '0;
                    qneg_d  = signed_op & (a[31] ^ b[31]);
                    rneg_d  = signed_op & a[31];
                    cnt_d   = '0;
                    state_d = DIV_BUSY;
                end
            end
            DIV_BUSY: begin
                // a zero divisor always "fits", yielding all-ones q and r = |a|
                rem_d = sub_ok ? rem_sub[31:0] : rem_sh[31:0];
                quo_d = {quo_q[30:0], sub_ok};
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == CNT_W'(ITERS - 1)) begin
                    state_d = DIV_DONE;
                end
            end
            DIV_DONE: begin
                if (advance) begin
                    state_d = DIV_IDLE;
                end
            end
            default: state_d = DIV_IDLE;
        endcase
    end

    assign unused_sub_msb = rem_sub[32];

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= DIV_IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_ff @(posedge clk) begin
        quo_q  <= quo_d;
        rem_q  <= rem_d;
        dvs_q  <= dvs_d;
        qneg_q <= qneg_d;
        rneg_q <= rneg_d;
    end

    assign busy = ((state_q == DIV_IDLE) && start) || (state_q == DIV_BUSY);
    assign done = (state_q == DIV_DONE);
    assign q    = neg_if(quo_q, qneg_q);
    assign r    = neg_if(rem_q, rneg_q);

endmodule

// File: rtl/ex_stage.sv
// MIPS execute stage: ID/EX register, 12-op ALU, HI/LO with MT/MF access, data
// SRAM request and the stall request raised while a divide is in flight.
module ex_stage
    import ex_stage_pkg::*;
(
    input  logic                    clk,
    input  logic                    rst,
    input  logic [STALL_WD-1:0]     stall,
    input  logic [ID_TO_EX_WD-1:0]  id_to_ex_bus,
    output logic [EX_TO_MEM_WD-1:0] ex_to_mem_bus,
    output logic [EX_TO_ID_WD-1:0]  ex_to_id_bus,
    output logic                    data_sram_en,
    output logic [3:0]              data_sram_wen,
    output logic [31:0]             data_sram_addr,
    output logic [31:0]             data_sram_wdata,
    output logic                    stallreq_for_ex
);

    id_to_ex_t          bus_q, bus_d;
    logic [31:0]        hi_q, hi_d, lo_q, lo_d;
    logic               is_special, is_div, is_divu, is_mfhi, is_mflo, is_mthi, is_mtlo;
    logic [31:0]        alu_src1, alu_src2, alu_res, ex_result;
    logic signed [31:0] src1_s, src2_s;
    logic               ex_rf_we;
    logic [4:0]         ex_rf_waddr;
    logic               advance, div_busy, div_done;
    logic [31:0]        div_q, div_r;
    logic               unused_bits;

    assign advance = (stall[2] == NO_STOP);

    // bubble when EX is stopped but MEM is not, so the held instruction is not duplicated
    always_comb begin
        bus_d = bus_q;
        if (stall[2] == STOP && stall[3] == NO_STOP) begin
            bus_d = '0;
        end else if (advance) begin
            bus_d = id_to_ex_bus;
        end
    end

    assign is_special = (bus_q.inst[31:26] == OP_SPECIAL);
    assign is_div     = is_special && (bus_q.inst[5:0] == FUNC_DIV);
    assign is_divu    = is_special && (bus_q.inst[5:0] == FUNC_DIVU);
    assign is_mfhi    = is_special && (bus_q.inst[5:0] == FUNC_MFHI);
    assign is_mflo    = is_special && (bus_q.inst[5:0] == FUNC_MFLO);
    assign is_mthi    = is_special && (bus_q.inst[5:0] == FUNC_MTHI);
    assign is_mtlo    = is_special && (bus_q.inst[5:0] == FUNC_MTLO);

    assign alu_src1 = ({32{bus_q.sel_alu_src1[SRC1_RS]}} & bus_q.rdata1)
                    | ({32{bus_q.sel_alu_src1[SRC1_PC]}} & bus_q.pc)
                    | ({32{bus_q.sel_alu_src1[SRC1_SA]}} & {27'b0, bus_q.inst[10:6]});
    assign alu_src2 = ({32{bus_q.sel_alu_src2[SRC2_RT]}}    & bus_q.rdata2)
                    | ({32{bus_q.sel_alu_src2[SRC2_SIMM]}}  & {{16{bus_q.inst[15]}}, bus_q.inst[15:0]})
                    | ({32{bus_q.sel_alu_src2[SRC2_EIGHT]}} & 32'd8)
                    | ({32{bus_q.sel_alu_src2[SRC2_ZIMM]}}  & {16'b0, bus_q.inst[15:0]});
    assign src1_s = alu_src1;
    assign src2_s = alu_src2;

    always_comb begin
        alu_res = '0;
        if (bus_q.alu_op[ALU_ADD])  alu_res = alu_src1 + alu_src2;
        if (bus_q.alu_op[ALU_SUB])  alu_res = alu_src1 - alu_src2;
        if (bus_q.alu_op[ALU_SLT])  alu_res = {31'b0, src1_s < src2_s};
        if (bus_q.alu_op[ALU_SLTU]) alu_res = {31'b0, alu_src1 < alu_src2};
        if (bus_q.alu_op[ALU_AND])  alu_res = alu_src1 & alu_src2;
        if (bus_q.alu_op[ALU_NOR])  alu_res = ~(alu_src1 | alu_src2);
        if (bus_q.alu_op[ALU_OR])   alu_res = alu_src1 | alu_src2;
        if (bus_q.alu_op[ALU_XOR])  alu_res = alu_src1 ^ alu_src2;
        if (bus_q.alu_op[ALU_SLL])  alu_res = alu_src2 << alu_src1[4:0];
        if (bus_q.alu_op[ALU_SRL])  alu_res = alu_src2 >> alu_src1[4:0];
        if (bus_q.alu_op[ALU_SRA])  alu_res = $unsigned(src2_s >>> alu_src1[4:0]);
        if (bus_q.alu_op[ALU_LUI])  alu_res = {alu_src2[15:0], 16'h0};
    end

    always_comb begin
        ex_result   = alu_res;
        ex_rf_we    = bus_q.rf_we;
        ex_rf_waddr = bus_q.rf_waddr;
        if (is_mfhi || is_mflo) begin
            ex_result   = is_mfhi ? hi_q : lo_q;
            ex_rf_we    = 1'b1;
            ex_rf_waddr = bus_q.inst[15:11];
        end else if (is_div || is_divu || is_mthi || is_mtlo) begin
            ex_rf_we = 1'b0;
        end
    end

    // divide results retire on the same edge that lets the next instruction in
    always_comb begin
        hi_d = hi_q;
        lo_d = lo_q;
        if (advance) begin
            if (div_done) begin
                hi_d = div_r;
                lo_d = div_q;
            end else begin
                if (is_mthi) hi_d = bus_q.rdata1;
                if (is_mtlo) lo_d = bus_q.rdata1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            bus_q <= '0;
            hi_q  <= '0;
            lo_q  <= '0;
        end else begin
            bus_q <= bus_d;
            hi_q  <= hi_d;
            lo_q  <= lo_d;
        end
    end

    ex_div #(.ITERS(DIV_ITERS)) u_div (
        .clk       (clk),
        .rst       (rst),
        .start     (is_div | is_divu),
        .signed_op (is_div),
        .a         (bus_q.rdata1),
        .b         (bus_q.rdata2),
        .advance   (advance),
        .busy      (div_busy),
        .done      (div_done),
        .q         (div_q),
        .r         (div_r)
    );

    assign unused_bits = ^{bus_q.inst[25:16], stall[5:4], stall[1:0]};

    assign stallreq_for_ex = div_busy;
    assign data_sram_en    = bus_q.data_ram_en;
    assign data_sram_wen   = bus_q.data_ram_wen;
    assign data_sram_addr  = alu_res;
    assign data_sram_wdata = bus_q.rdata2;
    assign ex_to_id_bus    = {ex_rf_we, ex_rf_waddr, ex_result};
    assign ex_to_mem_bus   = {bus_q.pc, bus_q.data_ram_en, bus_q.data_ram_wen, bus_q.sel_rf_res,
                              ex_rf_we, ex_rf_waddr, ex_result};

endmodule
